// File: rtl/pipeline_stall_ctrl.sv
// Stall/bubble producer for load-use, cache-miss, indirect-access and branch-squash hazards.
// Optional saturating stall counter enabled by defining HAZARD_STALL_CNT_EN.
//
// state | meaning
// RUN   | normal operation
// IND2  | first access of an LDI/STI completed, waiting for the second
// DROP  | fetch in flight after a redirect is stale; discard its response
module pipeline_stall_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_sr1,
  input  logic [REG_W-1:0] id_sr2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_sr1_used,
  input  logic             id_sr2_used,
  input  logic             id_dest_used,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_reg_write,
  input  logic             ex_is_load,
  input  logic             mem_dmem_req,
  input  logic             mem_indirect,
  input  logic             dmem_resp,
  input  logic             imem_resp,
  input  logic             branch_taken,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             if_id_bubble,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN = 2'd0, IND2 = 2'd1, DROP = 2'd2} state_t;

  state_t state, state_nxt;
  logic   dmem_stall;
  logic   load_use;

  assign dmem_stall = mem_dmem_req && (!dmem_resp || (mem_indirect && state != IND2));

  assign load_use = ex_is_load && ex_reg_write &&
                    ((id_sr1_used  && (id_sr1  == ex_dest)) ||
                     (id_sr2_used  && (id_sr2  == ex_dest)) ||
                     (id_dest_used && (id_dest == ex_dest)));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (mem_dmem_req && mem_indirect && dmem_resp)
          state_nxt = IND2;
        else if (!dmem_stall && branch_taken && !imem_resp)
          state_nxt = DROP;
      end
      IND2: begin
        if (!dmem_stall && branch_taken && !imem_resp)
          state_nxt = DROP;
        else if (mem_dmem_req && dmem_resp)
          state_nxt = RUN;
      end
      DROP: begin
        // Any response here is the stale one; a new redirect with no response keeps waiting.
        if (!dmem_stall && imem_resp)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_load       = 1'b1;
    if_id_load    = 1'b1;
    id_ex_load    = 1'b1;
    ex_mem_load   = 1'b1;
    mem_wb_load   = 1'b1;
    if_id_bubble  = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst_n) begin
      pc_load       = 1'b0;
      if_id_load    = 1'b0;
      id_ex_load    = 1'b0;
      ex_mem_load   = 1'b0;
      mem_wb_load   = 1'b0;
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (dmem_stall) begin
      pc_load       = 1'b0;
      if_id_load    = 1'b0;
      id_ex_load    = 1'b0;
      ex_mem_load   = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (load_use || !imem_resp) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state == DROP) begin
      if_id_bubble = 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (!pc_load && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

  assign stall_count = cnt;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl; counter checks follow HAZARD_STALL_CNT_EN.
module tb_pipeline_stall_ctrl;

  localparam int REG_W = 3;
  localparam int CNT_W = 4;
`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id, id_ex, ex_mem, mem_wb bubbles}
  localparam logic [8:0] RST    = 9'b00000_1111;
  localparam logic [8:0] DEF    = 9'b11111_0000;
  localparam logic [8:0] DSTALL = 9'b00001_0001;
  localparam logic [8:0] BR     = 9'b11111_1110;
  localparam logic [8:0] FSTALL = 9'b00111_0100;
  localparam logic [8:0] DROPR  = 9'b11111_1000;

  logic clk = 1'b0;
  logic rst_n;
  logic [REG_W-1:0] id_sr1, id_sr2, id_dest, ex_dest;
  logic id_sr1_used, id_sr2_used, id_dest_used;
  logic ex_reg_write, ex_is_load, mem_dmem_req, mem_indirect;
  logic dmem_resp, imem_resp, branch_taken;
  logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
  logic [CNT_W-1:0] stall_count;
  logic [8:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_sr1(id_sr1), .id_sr2(id_sr2), .id_dest(id_dest),
    .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used), .id_dest_used(id_dest_used),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_dmem_req(mem_dmem_req), .mem_indirect(mem_indirect),
    .dmem_resp(dmem_resp), .imem_resp(imem_resp), .branch_taken(branch_taken),
    .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
    .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
    .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
    .stall_count(stall_count)
  );

  assign outs = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                 if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble};

  task automatic idle();
    rst_n = 1'b1;
    id_sr1 = 3'd0; id_sr2 = 3'd0; id_dest = 3'd0; ex_dest = 3'd0;
    id_sr1_used = 1'b0; id_sr2_used = 1'b0; id_dest_used = 1'b0;
    ex_reg_write = 1'b0; ex_is_load = 1'b0;
    mem_dmem_req = 1'b0; mem_indirect = 1'b0; dmem_resp = 1'b0;
    imem_resp = 1'b1; branch_taken = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    #1;
    n_checks++;
    assert (outs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
    #1;
    n_checks++;
    assert (stall_count === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, stall_count, exp);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    next_cycle(); rst_n = 1'b0;                 chk("reset_outs", RST);
    next_cycle();                               chk_cnt("reset_cnt", '0);
    next_cycle(); idle();                       chk("idle", DEF);

    // load-use: LDR R2 in EX, ADD R3,R2,R1 in ID
    next_cycle(); ex_is_load = 1; ex_reg_write = 1; ex_dest = 3'd2;
                  id_sr1 = 3'd2; id_sr1_used = 1;  chk("load_use_sr1", FSTALL);
    next_cycle(); idle();                       chk("load_use_release", DEF);
    next_cycle(); ex_is_load = 1; ex_reg_write = 1; ex_dest = 3'd2;
                  id_sr1 = 3'd2; id_sr1_used = 0;  chk("lu_unused_sr1", DEF);
    next_cycle(); ex_reg_write = 0; id_sr1_used = 1; chk("lu_no_write", DEF);
    next_cycle(); idle(); ex_is_load = 1; ex_reg_write = 1; ex_dest = 3'd0;
                  id_dest = 3'd0; id_dest_used = 1; chk("lu_r0_dest", FSTALL);
    next_cycle(); idle(); ex_is_load = 1; ex_reg_write = 1; ex_dest = 3'd5;
                  id_sr2 = 3'd5; id_sr2_used = 1; id_sr1 = 3'd5; chk("lu_sr2", FSTALL);

    // LDR miss: 4 cycles without response, released on response
    next_cycle(); idle(); mem_dmem_req = 1; dmem_resp = 0; chk("dmem_miss_1", DSTALL);
    next_cycle();                               chk("dmem_miss_2", DSTALL);
    next_cycle();                               chk("dmem_miss_3", DSTALL);
    next_cycle();                               chk("dmem_miss_4", DSTALL);
    next_cycle(); dmem_resp = 1;                chk("dmem_release", DEF);

    // LDI: responses in cycles 3 and 7
    next_cycle(); idle(); mem_dmem_req = 1; mem_indirect = 1; chk("ldi_c1", DSTALL);
    next_cycle();                               chk("ldi_c2", DSTALL);
    next_cycle(); dmem_resp = 1;                chk("ldi_c3_first", DSTALL);
    next_cycle(); dmem_resp = 0;                chk("ldi_c4", DSTALL);
    next_cycle();                               chk("ldi_c5", DSTALL);
    next_cycle();                               chk("ldi_c6", DSTALL);
    next_cycle(); dmem_resp = 1;                chk("ldi_c7_release", DEF);
    next_cycle(); idle(); mem_dmem_req = 1; mem_indirect = 1; dmem_resp = 1;
                                                chk("ldi_back_in_run", DSTALL);
    next_cycle(); idle();                       chk("ldi_idle", DEF);

    // Branch with fetch outstanding, then the stale response is dropped
    next_cycle(); branch_taken = 1; imem_resp = 0; chk("br_squash", BR);
    next_cycle(); idle(); imem_resp = 0;        chk("drop_wait", FSTALL);
    next_cycle(); imem_resp = 1;                chk("drop_stale", DROPR);
    next_cycle();                               chk("drop_done", DEF);
    next_cycle(); branch_taken = 1;             chk("br_with_resp", BR);
    next_cycle(); idle();                       chk("br_no_drop", DEF);
    next_cycle(); imem_resp = 0;                chk("imem_stall", FSTALL);

    // dmem stall beats branch and load-use; branch honored on release
    next_cycle(); idle(); branch_taken = 1; ex_is_load = 1; ex_reg_write = 1;
                  ex_dest = 3'd1; id_sr1 = 3'd1; id_sr1_used = 1;
                  mem_dmem_req = 1; dmem_resp = 0; chk("prio_dmem", DSTALL);
    next_cycle(); dmem_resp = 1;                chk("prio_branch", BR);
    next_cycle(); idle();                       chk("prio_idle", DEF);

    // Stall counter saturation and clear
    next_cycle(); rst_n = 0;                    chk("reset_mid", RST);
    next_cycle(); idle(); imem_resp = 0;        chk_cnt("cnt_cleared", '0);
    repeat (3) next_cycle();                    chk_cnt("cnt_3", CNT_ON ? 4'd3 : 4'd0);
    repeat (17) next_cycle();                   chk_cnt("cnt_sat", CNT_ON ? 4'd15 : 4'd0);
    next_cycle(); rst_n = 0;
    next_cycle(); rst_n = 1; imem_resp = 1;     chk_cnt("cnt_reset", '0);
                                                chk("after_reset", DEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
